regfile_cmd_master: RTL and testbench
=====================================

Name: regfile_cmd_master

Overview:
- Command-driven initiator for the register file's write/read port set.
- Accepts READ, WRITE, COPY and CLEAR commands over a valid/ready handshake.
- Sequences them into register-file port activity, one access per cycle.
- Returns READ results over a valid/ready response channel.
- Sits between a host/debug/decode front-end and one register-file instance.

Parameters:
WIDTH, 32, data word width; must match the attached register file
N, 4, number of register entries; AW = $clog2(N) address bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  2  00 READ, 01 WRITE, 10 COPY, 11 CLEAR
cmd_adr_a  in  AW  READ/WRITE target; COPY source
cmd_adr_b  in  AW  COPY destination; ignored otherwise
cmd_data  in  WIDTH  WRITE data; ignored otherwise
rsp_valid  out  1  READ result valid
rsp_ready  in  1  response consumer ready
rsp_data  out  WIDTH  READ result
rf_write_en  out  1  to register file write_en
rf_read_en  out  1  to register file read_en
rf_write_adr  out  AW  to register file write_adr
rf_read_adr  out  AW  to register file read_adr
rf_data_in  out  WIDTH  to register file data_in
rf_data_out  in  WIDTH  from register file data_out; combinational read, valid in the same cycle as rf_read_en
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - clk rising edge with reset==0 -> state IDLE; all latched fields, the clear counter and rsp_data go to 0.
  - All outputs are 0 while reset is low, including cmd_ready.
  - Reset overrides every other event.
- States: IDLE, RD, RSP, WR, CP_RD, CP_WR, CLR.
- No combinational path from cmd_* or rsp_ready to any rf_* output. rf_* outputs decode from state and latched registers only.
- When no write is in progress: rf_write_en=0, rf_write_adr=0, rf_data_in=0.
- When no read is in progress: rf_read_en=0, rf_read_adr=0.
- IDLE:
  - cmd_ready=1; all other outputs 0.
  - Accept on cmd_valid & cmd_ready at edge T: latch op, adr_a, adr_b, data.
  - Next state by op: READ->RD, WRITE->WR, COPY->CP_RD, CLEAR->CLR with counter=0.
  - cmd_ready is 0 in every non-IDLE state, so commands are never queued.
- RD (cycle T+1):
  - rf_read_en=1, rf_read_adr=adr_a.
  - Capture rf_data_out into rsp_data at end of cycle; go to RSP.
- RSP:
  - rsp_valid=1; rsp_data held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready -> IDLE; rsp_valid drops the next cycle.
  - Minimum READ turnaround: accept at T, rsp_valid at T+2, cmd_ready again at T+3 if rsp_ready was high at T+2.
- WR (T+1): rf_write_en=1, rf_write_adr=adr_a, rf_data_in=data; then IDLE (cmd_ready=1 at T+2).
- CP_RD (T+1): rf_read_en=1, rf_read_adr=adr_a; latch rf_data_out into the copy buffer; go to CP_WR.
- CP_WR (T+2): rf_write_en=1, rf_write_adr=adr_b, rf_data_in=copy buffer; then IDLE.
  - adr_a==adr_b is legal: the same value is rewritten.
  - No response is generated for COPY.
- CLR (T+1 .. T+N):
  - rf_write_en=1, rf_write_adr=counter, rf_data_in=0; counter increments each cycle.
  - After writing address N-1 -> IDLE; counter returns to 0.
  - When N is not a power of two, addresses >= N are never driven.
- WRITE and CLEAR produce no response. rsp_valid is asserted only in RSP.
- Reset mid-operation (mid-CLEAR, mid-COPY, or pending RSP):
  - Aborts immediately. Pending response discarded; entries not yet written remain untouched by this block.
  - Command lost; the host must reissue.
- Address inputs are treated as unsigned, with no range check beyond AW bits.

Test Plan:
- Reset then WRITE adr_a=2, data=0xDEADBEEF -> at T+1 rf_write_en=1, rf_write_adr=2, rf_data_in=0xDEADBEEF; cmd_ready=1 at T+2; busy high for exactly 1 cycle.
- READ adr_a=2 with a model register file, rsp_ready=1 -> rf_read_en=1, rf_read_adr=2 at T+1; rsp_valid=1, rsp_data=0xDEADBEEF at T+2; cmd_ready=1 at T+3.
- READ with rsp_ready held low for 5 cycles -> rsp_valid and rsp_data stable for all 5 cycles; cmd_ready=0 throughout; cmd_valid pulses are ignored with no rf activity.
- COPY a=2, b=0 (rf[2]=0x12345678) -> read adr 2 at T+1, write adr 0 with 0x12345678 at T+2; subsequent READ 0 returns 0x12345678.
- CLEAR with N=4 after writing all entries -> write 0 to adrs 0,1,2,3 at T+1..T+4; cmd_ready=1 at T+5; READ of each entry returns 0.
- Assert reset at T+2 of a CLEAR -> next cycle all outputs 0 and state IDLE; entries 2 and 3 keep their values (model without its own reset clear); first cycle after reset release cmd_ready=1.

Source files
------------

// File: rtl/regfile_cmd_master.sv
// regfile_cmd_master: sequences READ/WRITE/COPY/CLEAR commands into one register-file port set.
// rf_* outputs decode only from state and latched fields; every output is forced low while reset is low.
module regfile_cmd_master #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_adr_a,
    input  logic [AW-1:0]    cmd_adr_b,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rf_write_en,
    output logic             rf_read_en,
    output logic [AW-1:0]    rf_write_adr,
    output logic [AW-1:0]    rf_read_adr,
    output logic [WIDTH-1:0] rf_data_in,
    input  logic [WIDTH-1:0] rf_data_out,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, RD, RSP, WR, CP_RD, CP_WR, CLR} state_t;
    state_t state, state_nx;
    logic [AW-1:0] adr_a, adr_b, cnt;
    logic [WIDTH-1:0] data, copy_buf, rsp_q;
    logic cnt_last;
    assign cnt_last = cnt == AW'(N - 1);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            adr_a    <= '0;
            adr_b    <= '0;
            data     <= '0;
            copy_buf <= '0;
            rsp_q    <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cmd_valid) begin
                adr_a <= cmd_adr_a;
                adr_b <= cmd_adr_b;
                data  <= cmd_data;
            end
            if (state == RD) rsp_q <= rf_data_out;
            if (state == CP_RD) copy_buf <= rf_data_out;
            cnt <= (state == CLR && !cnt_last) ? cnt + 1'b1 : '0;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_valid) state_nx = cmd_op == 2'b00 ? RD : cmd_op == 2'b01 ? WR :
                                               cmd_op == 2'b10 ? CP_RD : CLR;
            RD:      state_nx = RSP;
            RSP:     if (rsp_ready) state_nx = IDLE;
            WR:      state_nx = IDLE;
            CP_RD:   state_nx = CP_WR;
            CP_WR:   state_nx = IDLE;
            CLR:     if (cnt_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Gating with reset makes every output low for the whole reset cycle, not just after the edge.
    always_comb begin
        cmd_ready    = reset && state == IDLE;
        busy         = reset && state != IDLE;
        rsp_valid    = reset && state == RSP;
        rsp_data     = rsp_valid ? rsp_q : '0;
        rf_read_en   = reset && (state == RD || state == CP_RD);
        rf_read_adr  = rf_read_en ? adr_a : '0;
        rf_write_en  = reset && (state == WR || state == CP_WR || state == CLR);
        rf_write_adr = !rf_write_en ? '0 : state == WR ? adr_a : state == CP_WR ? adr_b : cnt;
        rf_data_in   = !rf_write_en ? '0 : state == WR ? data : state == CP_WR ? copy_buf : '0;
    end
endmodule

// File: tb/tb_regfile_cmd_master.sv
// tb_regfile_cmd_master: randomized and directed stimulus against an abstract register-file model,
// with READ results checked by a scoreboard monitor.
module tb_regfile_cmd_master;
    logic clk = 0;
    always #5 clk = ~clk;
    logic reset = 0, cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, busy;
    logic [1:0] cmd_op = 0, cmd_adr_a = 0, cmd_adr_b = 0, rf_write_adr, rf_read_adr;
    logic [31:0] cmd_data = 0, rsp_data, rf_data_in, rf_data_out;
    logic rf_write_en, rf_read_en;
    int checks = 0, errors = 0, mode = 0;
    logic [31:0] rf_mem [4] = '{default: 0};
    logic [31:0] ref_mem [4] = '{default: 0};
    logic [31:0] snap [4];
    logic [31:0] expq [$];

    regfile_cmd_master #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_adr_a(cmd_adr_a), .cmd_adr_b(cmd_adr_b), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rf_write_en(rf_write_en), .rf_read_en(rf_read_en),
        .rf_write_adr(rf_write_adr), .rf_read_adr(rf_read_adr), .rf_data_in(rf_data_in),
        .rf_data_out(rf_data_out), .busy(busy)
    );

    // Attached register file: no reset of its own, combinational read.
    always @(posedge clk) if (rf_write_en) rf_mem[rf_write_adr] <= rf_data_in;
    assign rf_data_out = rf_mem[rf_read_adr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #2;
        rsp_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    logic pv = 0, pr = 0;
    logic [31:0] pd = 0;
    always @(negedge clk) begin
        if (!reset) pv <= 0;
        else begin
            if (pv && !pr) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                if (rsp_valid) chk("rsp_hold_data", rsp_data, pd);
            end
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_data", rsp_data, expq.pop_front());
            end
            pv <= rsp_valid;
            pr <= rsp_ready;
            pd <= rsp_data;
        end
    end

    // Returns one tick into the cycle after acceptance (T+1); the model is updated at acceptance.
    task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, input logic [31:0] d);
        int n = 0;
        @(posedge clk);
        #1 cmd_valid = 1; cmd_op = op; cmd_adr_a = a; cmd_adr_b = b; cmd_data = d;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin n++; @(negedge clk); end
        if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 0;
        case (op)
            2'b00: expq.push_back(ref_mem[a]);
            2'b01: ref_mem[a] = d;
            2'b10: ref_mem[b] = ref_mem[a];
            default: for (int i = 0; i < 4; i++) ref_mem[i] = 0;
        endcase
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || busy) && n < 500) begin n++; @(negedge clk); end
        chk("drain", {31'd0, expq.size() == 0 && !busy}, 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_outs"}, {cmd_ready, busy, rsp_valid, rf_write_en, rf_read_en}, 0);
        chk({nm, "_data"}, rsp_data | rf_data_in | {28'd0, rf_write_adr, rf_read_adr}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        // WRITE
        send(2'b01, 2, 0, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_en", rf_write_en, 1);
        chk("wr_adr", rf_write_adr, 2);
        chk("wr_data", rf_data_in, 32'hDEADBEEF);
        chk("wr_busy", busy, 1);
        @(negedge clk);
        chk("wr_ready_after", {cmd_ready, busy, rf_write_en}, 3'b100);
        // READ, minimum turnaround
        send(2'b00, 2, 0, 0);
        @(negedge clk);
        chk("rd_en", {rf_read_en, rf_write_en}, 2'b10);
        chk("rd_adr", rf_read_adr, 2);
        @(negedge clk);
        chk("rd_rsp_valid", rsp_valid, 1);
        @(negedge clk);
        chk("rd_ready_after", {cmd_ready, rsp_valid}, 2'b10);
        // READ with a stalled consumer; stray command pulses must be ignored
        mode = 2;
        send(2'b00, 2, 0, 0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 cmd_valid = 1; cmd_op = 2'b01; cmd_adr_a = 1; cmd_data = 32'h55;
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_quiet", {cmd_ready, rf_write_en, rf_read_en}, 0);
        end
        cmd_valid = 0;
        mode = 0;
        drain();
        // COPY
        send(2'b01, 2, 0, 32'h12345678);
        send(2'b10, 2, 0, 0);
        @(negedge clk);
        chk("cp_rd", {rf_read_en, rf_write_en, 2'b00, rf_read_adr}, 6'b10_00_10);
        @(negedge clk);
        chk("cp_wr", {rf_read_en, rf_write_en, 2'b00, rf_write_adr}, 6'b01_00_00);
        chk("cp_data", rf_data_in, 32'h12345678);
        send(2'b00, 0, 0, 0);
        drain();
        // CLEAR
        for (int i = 0; i < 4; i++) send(2'b01, 2'(i), 0, $urandom);
        send(2'b11, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("clr_en", {rf_write_en, cmd_ready}, 2'b10);
            chk("clr_adr", rf_write_adr, i);
            chk("clr_data", rf_data_in, 0);
        end
        @(negedge clk);
        chk("clr_ready_after", {cmd_ready, rf_write_en}, 2'b10);
        for (int i = 0; i < 4; i++) send(2'b00, 2'(i), 0, 0);
        drain();
        // Reset in the middle of a CLEAR: only entry 0 has been cleared
        for (int i = 0; i < 4; i++) send(2'b01, 2'(i), 0, 32'hA0 + i);
        snap = ref_mem;
        send(2'b11, 0, 0, 0);
        ref_mem = snap;
        ref_mem[0] = 0;
        @(posedge clk);
        #1 reset = 0;
        expq.delete();
        @(negedge clk);
        chk_all_zero("abort");
        @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("abort_ready", {cmd_ready, busy}, 2'b10);
        chk("abort_e0", rf_mem[0], ref_mem[0]);
        chk("abort_e2", rf_mem[2], ref_mem[2]);
        chk("abort_e3", rf_mem[3], ref_mem[3]);
        send(2'b01, 1, 0, 32'hB1);
        // Random mix with a randomly stalling consumer
        mode = 1;
        repeat (80) send(2'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), $urandom);
        drain();
        mode = 0;
        for (int i = 0; i < 4; i++) send(2'b00, 2'(i), 0, 0);
        drain();
        for (int i = 0; i < 4; i++) chk("final_mem", rf_mem[i], ref_mem[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
